ps2_note_decoder: RTL

- Sits between the PS/2 keyboard controller and the note tone generator.
- Turns the raw scan-code byte stream (make codes, F0 break prefix, E0/E1 extended prefixes, typematic repeats) into a stable "currently held note key" code.
- Keeps a small last-pressed-priority stack of held keys. Releasing the newest key falls back to the previous still-held key; releasing the last key silences the output.
- Output code is the single-byte make code the tone generator's case table decodes.

---
 rtl/ps2_note_decoder_if.sv | 32 +++
 rtl/ps2_note_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder_if.sv
// PS/2 byte stream in, held-note status out, between keyboard controller and tone generator.
// DEPTH must match the decoder so stack_count has the right width.
interface ps2_note_decoder_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    ps2_key_data;
    logic          ps2_key_pressed;
    logic [7:0]    note_select;
    logic          note_active;
    logic          note_changed;
    logic [CW-1:0] stack_count;

    modport master (
        output ps2_key_data,
        output ps2_key_pressed,
        input  note_select,
        input  note_active,
        input  note_changed,
        input  stack_count
    );

    modport slave (
        input  ps2_key_data,
        input  ps2_key_pressed,
        output note_select,
        output note_active,
        output note_changed,
        output stack_count
    );
endinterface

// File: rtl/ps2_note_decoder.sv
// Scan-code stream to "currently held note" decoder with a last-pressed-priority key stack.
// Optional macro NOTE_FILTER_EN: only the 36 note keys are accepted as make codes.
module ps2_note_decoder #(
    parameter int DEPTH = 4
) (
    input logic           clock,
    input logic           reset,
    ps2_note_decoder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, BREAK, EXT, EXT_BREAK, SKIP} state_t;

    state_t        state;
    logic [2:0]    skip_count;
    logic [7:0]    stack [DEPTH];
    logic [CW-1:0] count;
    logic [7:0]    note_select_q;
    logic          note_active_q;
    logic          note_changed_q;

    logic [7:0]    code;
    logic          note_ok;
    logic          code_ignored;
    logic          do_push;
    logic          do_remove;
    logic          found;
    logic [CW-1:0] found_idx;
    logic [7:0]    stack_nx [DEPTH];
    logic [CW-1:0] count_nx;
    logic [7:0]    next_top;

    assign code = bus.ps2_key_data;

`ifdef NOTE_FILTER_EN
    function automatic logic is_note(input logic [7:0] c);
        case (c)
            8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36,
            8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h54,
            8'h55, 8'h5B, 8'h1C, 8'h1A, 8'h1B, 8'h22, 8'h21, 8'h2B, 8'h2A,
            8'h34, 8'h32, 8'h31, 8'h3B, 8'h3A, 8'h42, 8'h41, 8'h4B, 8'h49:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    assign note_ok = is_note(code);
`else
    assign note_ok = 1'b1;
`endif

    // Controller status/ack bytes that must never be mistaken for key presses
    always_comb begin
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: code_ignored = 1'b1;
            default:                                         code_ignored = 1'b0;
        endcase
    end

    always_comb begin
        do_push   = 1'b0;
        do_remove = 1'b0;
        if (bus.ps2_key_pressed) begin
            case (state)
                IDLE:    do_push = (code != 8'hF0) && (code != 8'hE0) && (code != 8'hE1)
                                   && !code_ignored && note_ok;
                BREAK:   do_remove = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && (CW'(i) < count) && (stack[i] == code)) begin
                found     = 1'b1;
                found_idx = CW'(i);
            end
        end
    end

    // Entry 0 is the oldest key; the newest held key sits at index count-1
    always_comb begin
        stack_nx = stack;
        count_nx = count;
        if (do_push && !found) begin
            if (count == CW'(DEPTH)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_nx[i] = stack[i + 1];
                end
                stack_nx[DEPTH - 1] = code;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == count) begin
                        stack_nx[i] = code;
                    end
                end
                count_nx = count + CW'(1);
            end
        end else if (do_remove && found) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (CW'(i) >= found_idx) begin
                    stack_nx[i] = stack[i + 1];
                end
            end
            stack_nx[DEPTH - 1] = 8'h00;
            count_nx = count - CW'(1);
        end
    end

    always_comb begin
        next_top = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if ((count_nx != '0) && (CW'(i) == count_nx - CW'(1))) begin
                next_top = stack_nx[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            skip_count     <= 3'd0;
            count          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= 8'h00;
            end
            note_select_q  <= 8'h00;
            note_active_q  <= 1'b0;
            note_changed_q <= 1'b0;
        end else begin
            stack          <= stack_nx;
            count          <= count_nx;
            note_select_q  <= next_top;
            note_active_q  <= (count_nx != '0);
            note_changed_q <= (next_top != note_select_q);
            if (bus.ps2_key_pressed) begin
                case (state)
                    IDLE: begin
                        if (code == 8'hF0) begin
                            state <= BREAK;
                        end else if (code == 8'hE0) begin
                            state <= EXT;
                        end else if (code == 8'hE1) begin
                            state      <= SKIP;
                            skip_count <= 3'd7;
                        end
                    end
                    BREAK:     state <= IDLE;
                    EXT:       state <= (code == 8'hF0) ? EXT_BREAK : IDLE;
                    EXT_BREAK: state <= IDLE;
                    // Pause key: E1 followed by seven more bytes that carry no note
                    SKIP: begin
                        if (skip_count == 3'd1) begin
                            state <= IDLE;
                        end
                        skip_count <= skip_count - 3'd1;
                    end
                    default:   state <= IDLE;
                endcase
            end
        end
    end

    assign bus.note_select  = note_select_q;
    assign bus.note_active  = note_active_q;
    assign bus.note_changed = note_changed_q;
    assign bus.stack_count  = count;
endmodule
